// File: rtl/iter_div.sv
// rtl/iter_div.sv - radix-2 restoring 32-bit divider with dual-operand stream input and 64-bit result stream
module iter_div #(
    parameter int SIGNED = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic        dvd_got;
    logic        dvs_got;
    logic [31:0] dvd_reg;
    logic [31:0] dvs_reg;
    logic [31:0] dvs_mag;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [4:0]  cnt;
    logic        q_neg;
    logic        r_neg;
    logic        dz;
    logic [63:0] dout_q;
    logic        dout_valid_q;

    logic        accept;
    logic        dvd_hs;
    logic        dvs_hs;
    logic        both_ready;
    logic [31:0] dvd_cur;
    logic [31:0] dvs_cur;
    logic        dvd_neg_c;
    logic        dvs_neg_c;
    logic [31:0] dvd_mag_c;
    logic [31:0] dvs_mag_c;
    logic [32:0] trial;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Operands are only taken while waiting or while presenting a result, one per channel.
    assign accept                 = (state == IDLE) || (state == DONE);
    assign s_axis_dividend_tready = accept && !dvd_got;
    assign s_axis_divisor_tready  = accept && !dvs_got;
    assign dvd_hs                 = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign dvs_hs                 = s_axis_divisor_tvalid && s_axis_divisor_tready;
    assign both_ready             = (dvd_got || dvd_hs) && (dvs_got || dvs_hs);

    assign m_axis_dout_tdata      = dout_q;
    assign m_axis_dout_tvalid     = dout_valid_q;

    // Operand values as seen at the start edge (bypass a handshake landing in the same cycle) and their magnitudes.
    always_comb begin
        dvd_cur   = dvd_hs ? s_axis_dividend_tdata : dvd_reg;
        dvs_cur   = dvs_hs ? s_axis_divisor_tdata  : dvs_reg;
        dvd_neg_c = (SIGNED != 0) && dvd_cur[31];
        dvs_neg_c = (SIGNED != 0) && dvs_cur[31];
        dvd_mag_c = dvd_neg_c ? (32'd0 - dvd_cur) : dvd_cur;
        dvs_mag_c = dvs_neg_c ? (32'd0 - dvs_cur) : dvs_cur;
    end

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor magnitude in 33 bits.
    always_comb begin
        trial   = {rem_q, quo_q[31]} - {1'b0, dvs_mag};
        rem_nxt = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
        quo_nxt = {quo_q[30:0], ~trial[32]};
    end

    // Final sign correction; a zero divisor yields all-ones quotient and the raw dividend as remainder.
    always_comb begin
        q_fix = dz ? 32'hFFFF_FFFF : (q_neg ? (32'd0 - quo_q) : quo_q);
        r_fix = dz ? dvd_reg       : (r_neg ? (32'd0 - rem_q) : rem_q);
    end

    // Control FSM with operand capture, iteration datapath and registered result.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            dvd_got      <= 1'b0;
            dvs_got      <= 1'b0;
            dvd_reg      <= 32'd0;
            dvs_reg      <= 32'd0;
            dvs_mag      <= 32'd0;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            cnt          <= 5'd0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            dz           <= 1'b0;
            dout_q       <= 64'd0;
            dout_valid_q <= 1'b0;
        end else begin
            if (dvd_hs) begin
                dvd_reg <= s_axis_dividend_tdata;
                dvd_got <= 1'b1;
            end
            if (dvs_hs) begin
                dvs_reg <= s_axis_divisor_tdata;
                dvs_got <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (both_ready) begin
                        state        <= CALC;
                        dout_valid_q <= 1'b0;
                        rem_q        <= 32'd0;
                        quo_q        <= dvd_mag_c;
                        dvs_mag      <= dvs_mag_c;
                        q_neg        <= dvd_neg_c ^ dvs_neg_c;
                        r_neg        <= dvd_neg_c;
                        dz           <= (dvs_cur == 32'd0);
                        cnt          <= 5'd0;
                    end else if (dvd_hs || dvs_hs) begin
                        state        <= IDLE;
                        dout_valid_q <= 1'b0;
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    dout_q       <= {q_fix, r_fix};
                    dout_valid_q <= 1'b1;
                    dvd_got      <= 1'b0;
                    dvs_got      <= 1'b0;
                    state        <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// tb/tb_iter_div.sv - scoreboard bench for iter_div, unsigned and signed instances driven in lockstep
module tb_iter_div;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] dvd_data = 32'd0;
    logic [31:0] dvs_data = 32'd0;
    logic        dvd_valid = 1'b0;
    logic        dvs_valid = 1'b0;
    logic        dvd_rdy_u, dvs_rdy_u, tv_u;
    logic        dvd_rdy_s, dvs_rdy_s, tv_s;
    logic [63:0] td_u, td_s;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] d;
        int          due;
    } exp_t;

    exp_t qu[$];
    exp_t qs[$];

    iter_div #(.SIGNED(0)) u_div_u (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_rdy_u),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_rdy_u),
        .m_axis_dout_tdata      (td_u),
        .m_axis_dout_tvalid     (tv_u)
    );

    iter_div #(.SIGNED(1)) u_div_s (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_rdy_s),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_rdy_s),
        .m_axis_dout_tdata      (td_s),
        .m_axis_dout_tvalid     (tv_s)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Offer selected operands; returns the cycle of the last handshake.
    task automatic xfer(input bit ua, input logic [31:0] a, input bit ub, input logic [31:0] b, output int hs);
        bit pa, pb;
        int t;
        pa = ua; pb = ub; hs = -1; t = 0;
        if (ua) dvd_data = a;
        if (ub) dvs_data = b;
        dvd_valid = ua;
        dvs_valid = ub;
        while ((pa || pb) && t < 100) begin
            if (pa && dvd_rdy_u) begin pa = 1'b0; hs = cyc; end
            if (pb && dvs_rdy_u) begin pb = 1'b0; hs = cyc; end
            step();
            t++;
            if (!pa && ua) begin dvd_valid = 1'b0; dvd_data = $urandom; end
            if (!pb && ub) begin dvs_valid = 1'b0; dvs_data = $urandom; end
        end
        if (pa || pb) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_timeout: got no handshake expected handshake within 100 cycles");
        end
    endtask

    task automatic push(input int hs, input logic [63:0] eu, input logic [63:0] es);
        qu.push_back('{eu, hs + 34});
        qs.push_back('{es, hs + 34});
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (tv_u !== 1'b1 && t < 100) begin
            step();
            t++;
        end
        if (tv_u !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: got tvalid %b expected 1 within 100 cycles", tv_u);
        end
    endtask

    // Monitor for the unsigned instance: compare on each tvalid rise, then watch for hold stability.
    initial begin
        exp_t        e;
        logic        pv;
        logic [63:0] hd;
        pv = 1'b0; hd = 64'd0;
        forever begin
            @(negedge clk);
            if (tv_u === 1'b1 && !pv) begin
                n_vec++;
                if (qu.size() == 0) begin
                    n_err++;
                    $display("FAIL result_u: got unexpected %h @%0d expected no result", td_u, cyc);
                end else begin
                    e = qu.pop_front();
                    if (td_u !== e.d || cyc != e.due) begin
                        n_err++;
                        $display("FAIL result_u: got %h @%0d expected %h @%0d", td_u, cyc, e.d, e.due);
                    end
                end
                hd = td_u;
            end else if (tv_u === 1'b1 && pv) begin
                n_vec++;
                if (td_u !== hd) begin
                    n_err++;
                    $display("FAIL hold_u: got %h expected %h", td_u, hd);
                end
            end
            pv = (tv_u === 1'b1);
        end
    end

    // Monitor for the signed instance.
    initial begin
        exp_t        e;
        logic        pv;
        logic [63:0] hd;
        pv = 1'b0; hd = 64'd0;
        forever begin
            @(negedge clk);
            if (tv_s === 1'b1 && !pv) begin
                n_vec++;
                if (qs.size() == 0) begin
                    n_err++;
                    $display("FAIL result_s: got unexpected %h @%0d expected no result", td_s, cyc);
                end else begin
                    e = qs.pop_front();
                    if (td_s !== e.d || cyc != e.due) begin
                        n_err++;
                        $display("FAIL result_s: got %h @%0d expected %h @%0d", td_s, cyc, e.d, e.due);
                    end
                end
                hd = td_s;
            end else if (tv_s === 1'b1 && pv) begin
                n_vec++;
                if (td_s !== hd) begin
                    n_err++;
                    $display("FAIL hold_s: got %h expected %h", td_s, hd);
                end
            end
            pv = (tv_s === 1'b1);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish before 600000 ns");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [63:0] eu [6];
    logic [63:0] es [6];

    initial begin
        int   hs, hs2;
        logic bad, bad2;

        va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;
        eu[0] = {32'h7FFF_FFFC, 32'd1};          es[0] = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
        va[1] = 32'd7;         vb[1] = 32'hFFFF_FFFE;
        eu[1] = {32'd0, 32'd7};                  es[1] = {32'hFFFF_FFFD, 32'd1};
        va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF;
        eu[2] = {32'd0, 32'h8000_0000};          es[2] = {32'h8000_0000, 32'd0};
        va[3] = 32'd5;         vb[3] = 32'd0;
        eu[3] = {32'hFFFF_FFFF, 32'd5};          es[3] = {32'hFFFF_FFFF, 32'd5};
        va[4] = 32'hFFFF_FFFB; vb[4] = 32'd0;
        eu[4] = {32'hFFFF_FFFF, 32'hFFFF_FFFB};  es[4] = {32'hFFFF_FFFF, 32'hFFFF_FFFB};
        va[5] = 32'hFFFF_FFFF; vb[5] = 32'd1;
        eu[5] = {32'hFFFF_FFFF, 32'd0};          es[5] = {32'hFFFF_FFFF, 32'd0};

        repeat (3) step();
        resetn = 1'b1;
        step();
        check("reset_rdy_u", {dvd_rdy_u, dvs_rdy_u}, 2'b11);
        check("reset_rdy_s", {dvd_rdy_s, dvs_rdy_s}, 2'b11);
        check("reset_out_u", {tv_u, td_u}, 65'd0);
        check("reset_out_s", {tv_s, td_s}, 65'd0);

        // 100 / 7 with both operands in the same cycle; readies must stay low through CALC and FIX.
        xfer(1'b1, 32'd100, 1'b1, 32'd7, hs);
        push(hs, {32'd14, 32'd2}, {32'd14, 32'd2});
        bad = 1'b0;
        repeat (33) begin
            if (dvd_rdy_u || dvs_rdy_u || dvd_rdy_s || dvs_rdy_s) bad = 1'b1;
            step();
        end
        check("tready_low_busy", bad, 1'b0);
        wait_valid();
        check("done_rdy", {dvd_rdy_u, dvs_rdy_u, dvd_rdy_s, dvs_rdy_s}, 4'b1111);

        // Back-to-back vectors, each offered in the first DONE cycle of the previous result.
        for (int i = 0; i < 6; i++) begin
            xfer(1'b1, va[i], 1'b1, vb[i], hs);
            push(hs, eu[i], es[i]);
            wait_valid();
        end

        // Hold for 10 idle cycles, then split arrival: dividend now, divisor five cycles later.
        repeat (10) step();
        xfer(1'b1, 32'h1234_5678, 1'b0, 32'd0, hs);
        check("tvalid_drop", {tv_u, tv_s}, 2'b00);
        bad = 1'b0; bad2 = 1'b0;
        repeat (4) begin
            if (dvd_rdy_u || dvd_rdy_s) bad = 1'b1;
            if (!dvs_rdy_u || !dvs_rdy_s) bad2 = 1'b1;
            step();
        end
        if (dvd_rdy_u || dvd_rdy_s) bad = 1'b1;
        if (!dvs_rdy_u || !dvs_rdy_s) bad2 = 1'b1;
        check("split_dvd_rdy_low", bad, 1'b0);
        check("split_dvs_rdy_high", bad2, 1'b0);
        xfer(1'b0, 32'd0, 1'b1, 32'h100, hs2);
        check("split_hs_cycle", hs2, hs + 5);
        push(hs2, {32'h0012_3456, 32'h78}, {32'h0012_3456, 32'h78});
        wait_valid();

        // Reset in the middle of CALC aborts with no output.
        step();
        xfer(1'b1, 32'hFFFF, 1'b1, 32'd3, hs);
        while (cyc < hs + 10) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("post_reset_rdy", {dvd_rdy_u, dvs_rdy_u, dvd_rdy_s, dvs_rdy_s}, 4'b1111);
        bad = 1'b0;
        repeat (45) begin
            if (tv_u !== 1'b0 || tv_s !== 1'b0 || td_u !== 64'd0 || td_s !== 64'd0) bad = 1'b1;
            step();
        end
        check("abort_no_output", bad, 1'b0);
        xfer(1'b1, 32'd9, 1'b1, 32'd3, hs);
        push(hs, {32'd3, 32'd0}, {32'd3, 32'd0});
        wait_valid();
        step();
        check("queues_drained", qu.size() + qs.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
